sound_mixer_dsm: RTL and testbench
==================================

SOUND_MIXER_DSM -- requirements
Module: sound_mixer_dsm

Interface
REQ-001 SHALL have parameter NCH, default 8: number of 8-bit unsigned audio channels, range 2..16.
REQ-002 SHALL have parameter SAMPLE_DIV, default 32: clk24 cycles per mix sample.
REQ-003 SHALL have parameter DSM_DIV, default 8: clk24 cycles per modulator step.
REQ-004 SHALL have parameter DSM_WIDTH, default 9: modulator input width.
REQ-005 SHALL have parameter MIX_SHIFT, default 3: right shift applied to the accumulated sum.
REQ-006 SHALL have parameter ORDER, default 1: modulator order, 1 or 2.
REQ-007 SHALL have parameter HYST, default 4: tape comparator hysteresis.
REQ-008 Port clk24, in, 1: single system clock; all logic is on its rising edge.
REQ-009 Port reset_n, in, 1: asynchronous active-low reset.
REQ-010 Port i_ch, in, NCH*8: channel k occupies bits [8k+7:8k], unsigned.
REQ-011 Port i_gain_we, in, 1: gain write strobe.
REQ-012 Port i_gain_addr, in, clog2(NCH)+1: MSB selects side (0=L, 1=R); LSBs select channel.
REQ-013 Port i_gain, in, 4: gain 0..15; 8 is unity.
REQ-014 Port i_tape_adc, in, 8: tape ADC sample, unsigned, midpoint 128.
REQ-015 Port o_tapein, out, 1: hysteresis-sliced tape bit.
REQ-016 Port o_pwm_l / o_pwm_r, out, 1 each: sigma-delta bitstreams.
REQ-017 Port o_mix_l / o_mix_r, out, DSM_WIDTH each: current latched mix samples.
REQ-018 Port o_mix_valid, out, 1: one-cycle pulse when new mix samples are latched.
REQ-019 Port o_overrun, out, 1: sticky flag; a sample tick was lost.

Function
REQ-020 Sample tick: a free-running counter SHALL assert tick for one cycle every SAMPLE_DIV clocks, with the first tick SAMPLE_DIV cycles after reset release.
REQ-021 Sequencer states SHALL be IDLE, ACCUM and LATCH.
- IDLE->ACCUM on tick; all i_ch are snapshotted in the same cycle.
- ACCUM lasts exactly NCH cycles and adds channel k (k=0..NCH-1) into both accumulators: acc_l += ch*gain_l[k]; acc_r += ch*gain_r[k].
- LATCH lasts 1 cycle, then returns to IDLE.
REQ-022 Accumulators SHALL be 12+clog2(NCH) bits wide and cleared on entry to ACCUM; no overflow is possible.
REQ-023 In LATCH, each side SHALL compute mix = acc >> MIX_SHIFT, saturated to 2^DSM_WIDTH-1.
- The result is registered into o_mix_l/o_mix_r, and o_mix_valid pulses in the following cycle.
- Latency: tick to o_mix_valid is NCH+2 cycles.
REQ-024 A tick arriving outside IDLE SHALL be dropped and SHALL set o_overrun; it is never set when SAMPLE_DIV >= NCH+2.
REQ-025 Gain writes SHALL take effect on the next clock edge.
- A write to the gain being read in the same cycle: the accumulation uses the old value.
- Writes are accepted in any state.
REQ-026 The modulator SHALL step only on its enable, which asserts every DSM_DIV clocks, and SHALL consume the latest o_mix value. Both sides are independent and identical.
REQ-027 ORDER=1: accu (DSM_WIDTH+1 bits) <= accu[DSM_WIDTH-1:0] + mix; o_pwm = accu[DSM_WIDTH].
REQ-028 ORDER=2: uses signed integrators i1 and i2, each DSM_WIDTH+4 bits.
- fb = 2^DSM_WIDTH if o_pwm else 0.
- i1 <= i1 + mix - fb; i2 <= i2 + i1 - fb.
- o_pwm registered as (i2 >= 0).
REQ-029 Tape comparator, each clock:
- i_tape_adc > 128+HYST sets o_tapein to 1.
- i_tape_adc < 128-HYST sets o_tapein to 0.
- Otherwise o_tapein holds its value.

Reset
REQ-030 reset_n low SHALL asynchronously set the following to 0: counters, accumulators, modulator state, o_pwm_l/r, o_mix_l/r, o_mix_valid, o_overrun and o_tapein. The sequencer SHALL go to IDLE.
REQ-031 reset SHALL set all gains to 8 (unity).
REQ-032 reset asserted mid-ACCUM SHALL discard the partial sum; no o_mix_valid is issued for that sample.

Structure
REQ-033 A shared package SHALL hold the sequencer state enum, the unity-gain constant (8) and the tape midpoint constant (128).
REQ-034 The modulator SHALL be one sub-module, sigma_delta_dac (parameters DSM_WIDTH and ORDER), instantiated once per side.

Verification
REQ-035 NCH=4, ch0=255 with L gain 8, all other channels 0 -> o_mix_l=255 and o_mix_valid exactly NCH+2 cycles after the tick.
REQ-036 All 4 channels=255, all gains=15, ORDER=1 -> o_mix_l saturates to 511, and o_pwm_l shows exactly 511 ones in 512 modulator steps starting from reset.
REQ-037 ch0=128, L gain 8, R gain 0 -> o_mix_l=128 and o_mix_r=0; over 512 steps o_pwm_l has 128 ones and o_pwm_r is constant 0.
REQ-038 SAMPLE_DIV=4, NCH=4 -> o_overrun sets at the first overlapping tick and stays set until reset.
REQ-039 i_tape_adc sequence 100,130,133,126,123 (HYST=4) -> o_tapein 0,0,1,1,0.
REQ-040 reset_n pulsed low during ACCUM -> all outputs read 0 immediately; the next tick produces a correct mix computed with unity gains.

Source files
------------

// File: rtl/sound_mixer_dsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sound_mixer_dsm_pkg
// Summary  : Shared types and constants for the sound mixer / DSM block.
// Revision : 1.0
// ============================================================================
package sound_mixer_dsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_LATCH = 2'd2
  } seq_state_t;

  localparam logic [3:0] C_UNITY_GAIN = 4'd8;
  localparam logic [7:0] C_TAPE_MID   = 8'd128;

endpackage
`default_nettype wire

// File: rtl/sound_mixer_dsm_dac.sv
`default_nettype none
// ============================================================================
// Module   : sigma_delta_dac
// Summary  : First- or second-order sigma-delta modulator, one step per i_en.
// Revision : 1.0
// ============================================================================
module sigma_delta_dac #(
  parameter int DSM_WIDTH = 9,
  parameter int ORDER     = 1
) (
  input  logic                 clk24,
  input  logic                 reset_n,
  input  logic                 i_en,
  input  logic [DSM_WIDTH-1:0] i_mix,
  output logic                 o_pwm
);

  generate
    if (ORDER == 2) begin : g_order2
      localparam int C_IW = DSM_WIDTH + 4;
      localparam logic signed [C_IW-1:0] C_FB = {4'b0001, {DSM_WIDTH{1'b0}}};

      logic signed [C_IW-1:0] r_i1;
      logic signed [C_IW-1:0] r_i2;
      logic signed [C_IW-1:0] w_fb;
      logic signed [C_IW-1:0] w_mix;
      logic signed [C_IW-1:0] w_i1_nxt;
      logic signed [C_IW-1:0] w_i2_nxt;
      logic                   r_pwm;

      assign w_fb     = r_pwm ? C_FB : '0;
      assign w_mix    = {4'b0000, i_mix};
      assign w_i1_nxt = r_i1 + w_mix - w_fb;
      assign w_i2_nxt = r_i2 + r_i1 - w_fb;

      always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
          r_i1  <= '0;
          r_i2  <= '0;
          r_pwm <= 1'b0;
        end else if (i_en) begin
          r_i1  <= w_i1_nxt;
          r_i2  <= w_i2_nxt;
          r_pwm <= ~w_i2_nxt[C_IW-1];
        end
      end

      assign o_pwm = r_pwm;
    end else begin : g_order1
      // Carry out of the phase accumulator is the output bit.
      logic [DSM_WIDTH:0] r_accu;

      always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
          r_accu <= '0;
        end else if (i_en) begin
          r_accu <= {1'b0, r_accu[DSM_WIDTH-1:0]} + {1'b0, i_mix};
        end
      end

      assign o_pwm = r_accu[DSM_WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sound_mixer_dsm.sv
`default_nettype none
// ============================================================================
// Module   : sound_mixer_dsm
// Summary  : NCH-channel stereo gain mixer feeding sigma-delta DACs, plus tape slicer.
// Revision : 1.0
// ============================================================================
module sound_mixer_dsm #(
  parameter int NCH        = 8,
  parameter int SAMPLE_DIV = 32,
  parameter int DSM_DIV    = 8,
  parameter int DSM_WIDTH  = 9,
  parameter int MIX_SHIFT  = 3,
  parameter int ORDER      = 1,
  parameter int HYST       = 4
) (
  input  logic                  clk24,
  input  logic                  reset_n,
  input  logic [NCH*8-1:0]      i_ch,
  input  logic                  i_gain_we,
  input  logic [$clog2(NCH):0]  i_gain_addr,
  input  logic [3:0]            i_gain,
  input  logic [7:0]            i_tape_adc,
  output logic                  o_tapein,
  output logic                  o_pwm_l,
  output logic                  o_pwm_r,
  output logic [DSM_WIDTH-1:0]  o_mix_l,
  output logic [DSM_WIDTH-1:0]  o_mix_r,
  output logic                  o_mix_valid,
  output logic                  o_overrun
);
  import sound_mixer_dsm_pkg::*;

  localparam int C_IDX_W   = $clog2(NCH);
  localparam int C_ACC_W   = 12 + C_IDX_W;
  localparam int C_SC_W    = $clog2(SAMPLE_DIV + 1);
  localparam int C_DC_W    = $clog2(DSM_DIV + 1);
  localparam int C_MIX_MAX = (1 << DSM_WIDTH) - 1;
  localparam logic [8:0] C_TAPE_HI = 9'(C_TAPE_MID) + 9'(HYST);
  localparam logic [8:0] C_TAPE_LO = 9'(C_TAPE_MID) - 9'(HYST);

  seq_state_t           r_state, w_state_nxt;
  logic [C_SC_W-1:0]    r_smp_cnt;
  logic [C_DC_W-1:0]    r_dsm_cnt;
  logic [C_IDX_W-1:0]   r_idx;
  logic [7:0]           r_snap   [NCH];
  logic [3:0]           r_gain_l [NCH];
  logic [3:0]           r_gain_r [NCH];
  logic [C_ACC_W-1:0]   r_acc_l, r_acc_r;
  logic [DSM_WIDTH-1:0] r_mix_l, r_mix_r;
  logic                 r_mix_valid, r_overrun, r_tapein;
  logic                 w_tick, w_dsm_en, w_start, w_acc_en, w_latch;
  logic [11:0]          w_prod_l, w_prod_r;
  logic [C_ACC_W-1:0]   w_shift_l, w_shift_r;
  logic [DSM_WIDTH-1:0] w_sat_l, w_sat_r;

  assign w_tick   = (r_smp_cnt == C_SC_W'(SAMPLE_DIV - 1));
  assign w_dsm_en = (r_dsm_cnt == C_DC_W'(DSM_DIV - 1));

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_smp_cnt <= '0;
      r_dsm_cnt <= '0;
    end else begin
      r_smp_cnt <= w_tick   ? '0 : r_smp_cnt + C_SC_W'(1);
      r_dsm_cnt <= w_dsm_en ? '0 : r_dsm_cnt + C_DC_W'(1);
    end
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_tick) w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (r_idx == C_IDX_W'(NCH - 1)) w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start  = 1'b0;
    w_acc_en = 1'b0;
    w_latch  = 1'b0;
    case (r_state)
      ST_IDLE:  w_start  = w_tick;
      ST_ACCUM: w_acc_en = 1'b1;
      ST_LATCH: w_latch  = 1'b1;
      default:  ;
    endcase
  end

  // Gain writes land at the next edge, so an in-flight read sees the old value.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        r_gain_l[k] <= C_UNITY_GAIN;
        r_gain_r[k] <= C_UNITY_GAIN;
      end
    end else if (i_gain_we) begin
      for (int k = 0; k < NCH; k++) begin
        if (i_gain_addr[C_IDX_W-1:0] == C_IDX_W'(k)) begin
          if (i_gain_addr[C_IDX_W]) r_gain_r[k] <= i_gain;
          else                      r_gain_l[k] <= i_gain;
        end
      end
    end
  end

  assign w_prod_l  = {4'b0000, r_snap[r_idx]} * {8'b0, r_gain_l[r_idx]};
  assign w_prod_r  = {4'b0000, r_snap[r_idx]} * {8'b0, r_gain_r[r_idx]};
  assign w_shift_l = r_acc_l >> MIX_SHIFT;
  assign w_shift_r = r_acc_r >> MIX_SHIFT;
  assign w_sat_l   = (w_shift_l > C_ACC_W'(C_MIX_MAX)) ? DSM_WIDTH'(C_MIX_MAX)
                                                       : w_shift_l[DSM_WIDTH-1:0];
  assign w_sat_r   = (w_shift_r > C_ACC_W'(C_MIX_MAX)) ? DSM_WIDTH'(C_MIX_MAX)
                                                       : w_shift_r[DSM_WIDTH-1:0];

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) r_snap[k] <= '0;
      r_idx       <= '0;
      r_acc_l     <= '0;
      r_acc_r     <= '0;
      r_mix_l     <= '0;
      r_mix_r     <= '0;
      r_mix_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_mix_valid <= w_latch;
      if (w_tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      if (w_start) begin
        for (int k = 0; k < NCH; k++) r_snap[k] <= i_ch[8*k +: 8];
        r_idx   <= '0;
        r_acc_l <= '0;
        r_acc_r <= '0;
      end else if (w_acc_en) begin
        r_idx   <= r_idx + C_IDX_W'(1);
        r_acc_l <= r_acc_l + {{C_IDX_W{1'b0}}, w_prod_l};
        r_acc_r <= r_acc_r + {{C_IDX_W{1'b0}}, w_prod_r};
      end
      if (w_latch) begin
        r_mix_l <= w_sat_l;
        r_mix_r <= w_sat_r;
      end
    end
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n)                                r_tapein <= 1'b0;
    else if ({1'b0, i_tape_adc} > C_TAPE_HI)     r_tapein <= 1'b1;
    else if ({1'b0, i_tape_adc} < C_TAPE_LO)     r_tapein <= 1'b0;
  end

  sigma_delta_dac #(.DSM_WIDTH(DSM_WIDTH), .ORDER(ORDER)) u_dac_l (
    .clk24   (clk24),
    .reset_n (reset_n),
    .i_en    (w_dsm_en),
    .i_mix   (r_mix_l),
    .o_pwm   (o_pwm_l)
  );

  sigma_delta_dac #(.DSM_WIDTH(DSM_WIDTH), .ORDER(ORDER)) u_dac_r (
    .clk24   (clk24),
    .reset_n (reset_n),
    .i_en    (w_dsm_en),
    .i_mix   (r_mix_r),
    .o_pwm   (o_pwm_r)
  );

  assign o_mix_l     = r_mix_l;
  assign o_mix_r     = r_mix_r;
  assign o_mix_valid = r_mix_valid;
  assign o_overrun   = r_overrun;
  assign o_tapein    = r_tapein;

endmodule
`default_nettype wire

// File: tb/tb_sound_mixer_dsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_mixer_dsm
// Summary  : Self-checking bench for sound_mixer_dsm against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_sound_mixer_dsm;

  localparam int NCH   = 4;
  localparam int SDIV  = 32;
  localparam int DDIV  = 8;
  localparam int DW    = 9;
  localparam int SHIFT = 3;
  localparam int MAXV  = (1 << DW) - 1;

  logic          clk24   = 1'b0;
  logic          reset_n = 1'b1;
  logic [NCH*8-1:0] ch;
  logic          gain_we;
  logic [2:0]    gain_addr;
  logic [3:0]    gain;
  logic [7:0]    tape;

  logic          tapein, pwm_l, pwm_r, mix_valid, overrun;
  logic [DW-1:0] mix_l, mix_r;
  logic          o2_tapein, o2_pwm_l, o2_pwm_r, o2_mix_valid, o2_overrun;
  logic [DW-1:0] o2_mix_l, o2_mix_r;
  logic          ov_tapein, ov_pwm_l, ov_pwm_r, ov_mix_valid, ov_overrun;
  logic [DW-1:0] ov_mix_l, ov_mix_r;
  logic          ed_tapein, ed_pwm_l, ed_pwm_r, ed_mix_valid, ed_overrun;
  logic [DW-1:0] ed_mix_l, ed_mix_r;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int gl[NCH];
  int gr[NCH];

  always #5 clk24 = ~clk24;

  always @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  sound_mixer_dsm #(.NCH(NCH), .SAMPLE_DIV(SDIV), .DSM_DIV(DDIV), .DSM_WIDTH(DW),
                    .MIX_SHIFT(SHIFT), .ORDER(1), .HYST(4)) u_dut (
    .clk24(clk24), .reset_n(reset_n), .i_ch(ch), .i_gain_we(gain_we),
    .i_gain_addr(gain_addr), .i_gain(gain), .i_tape_adc(tape), .o_tapein(tapein),
    .o_pwm_l(pwm_l), .o_pwm_r(pwm_r), .o_mix_l(mix_l), .o_mix_r(mix_r),
    .o_mix_valid(mix_valid), .o_overrun(overrun));

  sound_mixer_dsm #(.NCH(NCH), .SAMPLE_DIV(SDIV), .DSM_DIV(DDIV), .DSM_WIDTH(DW),
                    .MIX_SHIFT(SHIFT), .ORDER(2), .HYST(4)) u_o2 (
    .clk24(clk24), .reset_n(reset_n), .i_ch(ch), .i_gain_we(gain_we),
    .i_gain_addr(gain_addr), .i_gain(gain), .i_tape_adc(tape), .o_tapein(o2_tapein),
    .o_pwm_l(o2_pwm_l), .o_pwm_r(o2_pwm_r), .o_mix_l(o2_mix_l), .o_mix_r(o2_mix_r),
    .o_mix_valid(o2_mix_valid), .o_overrun(o2_overrun));

  sound_mixer_dsm #(.NCH(NCH), .SAMPLE_DIV(4), .DSM_DIV(DDIV), .DSM_WIDTH(DW),
                    .MIX_SHIFT(SHIFT), .ORDER(1), .HYST(4)) u_ovr (
    .clk24(clk24), .reset_n(reset_n), .i_ch(ch), .i_gain_we(gain_we),
    .i_gain_addr(gain_addr), .i_gain(gain), .i_tape_adc(tape), .o_tapein(ov_tapein),
    .o_pwm_l(ov_pwm_l), .o_pwm_r(ov_pwm_r), .o_mix_l(ov_mix_l), .o_mix_r(ov_mix_r),
    .o_mix_valid(ov_mix_valid), .o_overrun(ov_overrun));

  sound_mixer_dsm #(.NCH(NCH), .SAMPLE_DIV(NCH + 2), .DSM_DIV(DDIV), .DSM_WIDTH(DW),
                    .MIX_SHIFT(SHIFT), .ORDER(1), .HYST(4)) u_edge (
    .clk24(clk24), .reset_n(reset_n), .i_ch(ch), .i_gain_we(gain_we),
    .i_gain_addr(gain_addr), .i_gain(gain), .i_tape_adc(tape), .o_tapein(ed_tapein),
    .o_pwm_l(ed_pwm_l), .o_pwm_r(ed_pwm_r), .o_mix_l(ed_mix_l), .o_mix_r(ed_mix_r),
    .o_mix_valid(ed_mix_valid), .o_overrun(ed_overrun));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sum of channel*gain over all channels, scaled and clipped to the DAC range.
  function automatic int model_mix(input int side);
    int s = 0;
    for (int k = 0; k < NCH; k++) s += int'(ch[8*k +: 8]) * ((side != 0) ? gr[k] : gl[k]);
    s = s >> SHIFT;
    return (s > MAXV) ? MAXV : s;
  endfunction

  task automatic step();
    @(posedge clk24);
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk24);
    for (int k = 0; k < NCH; k++) begin gl[k] = 8; gr[k] = 8; end
    reset_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk24);
    reset_n = 1'b0;
    gain_we = 1'b0;
    release_reset();
  endtask

  task automatic write_gain(input int side, input int k, input int val);
    gain_we   = 1'b1;
    gain_addr = {side[0], k[1:0]};
    gain      = val[3:0];
    step();
    gain_we   = 1'b0;
    if (side != 0) gr[k] = val; else gl[k] = val;
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin step(); n++; end while (!mix_valid && n < 200);
    if (!mix_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    do begin step(); n++; end while ((cyc % SDIV) != ph && n < 2 * SDIV);
  endtask

  task automatic count_steps(input int nsteps, output int ones_l, output int ones_r,
                             output int ones_o2);
    int n = 0;
    ones_l = 0; ones_r = 0; ones_o2 = 0;
    while (n < nsteps) begin
      step();
      if (cyc % DDIV == 0) begin
        n++;
        ones_l  += int'(pwm_l);
        ones_r  += int'(pwm_r);
        ones_o2 += int'(o2_pwm_l);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mix_l"},  int'(mix_l), 0);
    check({tag, "_mix_r"},  int'(mix_r), 0);
    check({tag, "_valid"},  int'(mix_valid), 0);
    check({tag, "_pwm_l"},  int'(pwm_l), 0);
    check({tag, "_pwm_r"},  int'(pwm_r), 0);
    check({tag, "_ovr"},    int'(overrun), 0);
    check({tag, "_tapein"}, int'(tapein), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ol, orr, o2;
    int exp_l, exp_r, k;
    int tv[5] = '{100, 130, 133, 126, 123};
    int te[5] = '{0, 0, 1, 1, 0};

    ch = '0; ch[7:0] = 8'd255;
    gain_we = 1'b0; gain_addr = '0; gain = '0; tape = 8'd128;

    #2 reset_n = 1'b0;
    #1 check_zero("por");
    release_reset();

    repeat (8) begin
      step();
      if (cyc == 7) check("ovr_before_overlap", int'(ov_overrun), 0);
      if (cyc == 8) check("ovr_at_overlap", int'(ov_overrun), 1);
    end

    // First sample: ch0=255 at unity gain on both sides.
    wait_valid();
    check("first_valid_cycle", cyc, SDIV + NCH + 1);
    check("first_mix_l", int'(mix_l), 255);
    check("first_mix_r", int'(mix_r), model_mix(1));
    step();
    check("valid_one_cycle", int'(mix_valid), 0);

    for (int i = 0; i < 5; i++) begin
      tape = tv[i][7:0];
      step();
      check($sformatf("tape_%0d", i), int'(tapein), te[i]);
    end

    for (int it = 0; it < 6; it++) begin
      ch = NCH*8'($urandom);
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < NCH; c++) write_gain(s, c, $urandom_range(0, 15));
      wait_valid();
      check($sformatf("rand_mix_l_%0d", it), int'(mix_l), model_mix(0));
      check($sformatf("rand_mix_r_%0d", it), int'(mix_r), model_mix(1));
    end

    // Gain write landing on the same edge that reads that gain.
    ch = NCH*8'($urandom);
    ch[23:16] = ch[23:16] | 8'h81;
    exp_l = model_mix(0);
    exp_r = model_mix(1);
    wait_phase(2);
    write_gain(0, 2, (gl[2] + 5) % 16);
    wait_valid();
    check("same_cycle_write_l", int'(mix_l), exp_l);
    check("same_cycle_write_r", int'(mix_r), exp_r);
    wait_valid();
    check("after_write_l", int'(mix_l), model_mix(0));

    // Full-scale saturation and first-order density.
    do_reset();
    ch = '1;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < NCH; c++) write_gain(s, c, 15);
    wait_valid();
    check("sat_mix_l", int'(mix_l), MAXV);
    check("sat_mix_r", int'(mix_r), model_mix(1));
    count_steps(512, ol, orr, o2);
    check("sat_ones_l", ol, (512 * MAXV) >> DW);
    check("sat_ones_r", orr, (512 * MAXV) >> DW);

    // ch0=128, L unity, R muted.
    do_reset();
    ch = '0; ch[7:0] = 8'd128;
    for (int c = 0; c < NCH; c++) write_gain(1, c, 0);
    wait_valid();
    check("q_mix_l", int'(mix_l), 128);
    check("q_mix_r", int'(mix_r), 0);
    count_steps(512, ol, orr, o2);
    check("q_ones_l", ol, (512 * 128) >> DW);
    check("q_ones_r", orr, 0);
    check("q_order2_density", int'(o2 >= 120 && o2 <= 136), 1);

    // Asynchronous reset in the middle of an accumulation.
    tape = 8'd200;
    wait_valid();
    ch = NCH*8'($urandom);
    ch[7:0] = ch[7:0] | 8'h80;
    wait_phase(2);
    check("pre_reset_tapein", int'(tapein), 1);
    check("pre_reset_mix_l", int'(mix_l != 0), 1);
    #2 reset_n = 1'b0;
    #1 check_zero("arst");
    tape = 8'd128;
    release_reset();
    wait_valid();
    check("post_reset_valid_cycle", cyc, SDIV + NCH + 1);
    check("post_reset_mix_l", int'(mix_l), model_mix(0));
    check("post_reset_mix_r", int'(mix_r), model_mix(1));

    repeat (40) step();
    k = 0;
    check("ovr_sticky", int'(ov_overrun), 1);
    check("ovr_edge_div", int'(ed_overrun), k);
    check("ovr_main", int'(overrun), k);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
